// File: rtl/xrv_pkg.sv
// Shared types and constants for the RV32M iterative multiplier.
package xrv_pkg;

    // Operation encodings as they arrive from the decoder on `op`.
    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,  // low word, sign-independent
        MUL_HSS = 2'b01,  // high word, signed x signed
        MUL_HSU = 2'b10,  // high word, signed x unsigned
        MUL_HUU = 2'b11   // high word, unsigned x unsigned
    } mul_op_e;

    // Control states of the shift-add sequencer.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_CALC = 2'b01,
        MUL_DONE = 2'b10
    } mul_st_e;

    // One iteration per multiplier bit.
    localparam int unsigned MUL_ITER = 32;

endpackage

// File: rtl/xrv_mul.sv
// Iterative 32x32 multiplier for the RV32M execute stage.
// Radix-2 shift-add over 32 cycles on operand magnitudes, with the sign
// reapplied to the full 64-bit product at the end.
module xrv_mul
    import xrv_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic [1:0]  op,
    input  logic        valid,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid
);

    // Control state (reset)
    mul_st_e     state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;

    // Datapath state (not reset)
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic        neg_q, neg_d;
    mul_op_e     op_q, op_d;

    // Sequencer strobes
    logic        accept;
    logic        iterate;

    // Request decode
    mul_op_e     op_in;
    logic        rs1_signed;
    logic        rs2_signed;
    logic        rs1_neg;
    logic        rs2_neg;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;

    // Iteration and finish
    logic [32:0] sum;
    logic [63:0] prod;

    // Operand signedness and magnitude conversion for an incoming request.
    always_comb begin
        op_in      = mul_op_e'(op);
        rs1_signed = (op_in == MUL_HSS) || (op_in == MUL_HSU);
        rs2_signed = (op_in == MUL_HSS);
        rs1_neg    = rs1_signed && multiplicand[31];
        rs2_neg    = rs2_signed && multiplier[31];
        // 0x80000000 negates to itself and is then used as an unsigned magnitude.
        rs1_mag    = rs1_neg ? (~multiplicand + 32'd1) : multiplicand;
        rs2_mag    = rs2_neg ? (~multiplier + 32'd1) : multiplier;
    end

    // One shift-add step and the signed 64-bit product.
    always_comb begin
        sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    end

    // Next-state, strobes and registered outputs.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        accept         = 1'b0;
        iterate        = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (valid && !flush) begin
                    accept  = 1'b1;
                    count_d = '0;
                    state_d = MUL_CALC;
                end
            end
            MUL_CALC: begin
                if (flush) begin
                    state_d = MUL_IDLE;
                end else begin
                    iterate = 1'b1;
                    if (count_q == 5'(MUL_ITER - 1)) begin
                        state_d = MUL_DONE;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            MUL_DONE: begin
                if (flush) begin
                    state_d = MUL_IDLE;
                end else begin
                    result_d       = (op_q == MUL_LO) ? prod[31:0] : prod[63:32];
                    result_valid_d = 1'b1;
                    state_d        = MUL_IDLE;
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // Datapath load on accept, shift-add on each iteration.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        op_d    = op_q;
        if (accept) begin
            acc_d   = {32'd0, rs2_mag};
            mcand_d = rs1_mag;
            neg_d   = rs1_neg ^ rs2_neg;
            op_d    = op_in;
        end else if (iterate) begin
            acc_d = {sum, acc_q[31:1]};
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= MUL_IDLE;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Datapath registers; their contents are only meaningful after an accept.
    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
        neg_q   <= neg_d;
        op_q    <= op_d;
    end

    assign busy         = (state_q != MUL_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
